// File: rtl/apb_arb_pkg.sv
// Shared definitions for the APB request arbiter.
//   arb_state_t   : FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   SEL_W_DEF     : default width of the passed-through slave select
//   idx_width()   : bit width needed to hold values 0..v-1, never below 1
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

    localparam int SEL_W_DEF = 3;

    // Used both for the requester index and for the wait-state counter,
    // whose largest value is TIMEOUT-1.
    function automatic int idx_width(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index with highest priority this round
//   gnt_oh : one-hot winner (all zero when no request)
//   idx    : encoded winner index (0 when no request)
//   any    : at least one request present
// The winner is the first set request at or above ptr; if none exists
// there, the search wraps to the lowest set request below ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [NUM_REQ-1:0] hi_req;
    logic               found;

    assign any = |req;

    always_comb begin
        hi_req = '0;
        found  = 1'b0;
        idx    = '0;
        gnt_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi_req[i] = req[i] && (IW'(i) >= ptr);
        end
        // First pass: requests at or after the pointer.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && hi_req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        // Second pass: wrap around to the lowest request.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_oh[i] = any && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB bus between NUM_REQ requesters with round-robin arbitration.
// Each granted transfer runs SETUP -> ACCESS (with wait states / timeout) ->
// RESP, then the FSM returns to IDLE for the next arbitration.
// Ports:
//   hclk, hresetn                  clock, async active-high reset
//   req/req_write/req_addr/
//   req_wdata/req_sel              per-requester request and packed payload
//   gnt, done                      one-hot grant, one-cycle completion pulse
//   rdata, err                     transfer result, valid with done, held after
//   psel/penable/pwrite/
//   paddr/pwdata                   APB master outputs
//   prdata/pready/pslverr          APB slave response
//   dbg_state                      current FSM state
//
// Handshake: req[i] is a level "valid" held by requester i together with its
// payload; done[i] is the acknowledge. The payload is captured only in IDLE,
// so anything a requester does between grant and done is ignored. A requester
// must drop req[i] in the cycle after done[i] unless it wants another transfer.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                      hclk,
    input  logic                      hresetn,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic [SEL_W-1:0]          psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr,
    output arb_state_t                dbg_state
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int CW = idx_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [IW-1:0]       win_q;
    logic [IW-1:0]       rr_q;
    logic [CW-1:0]       cnt_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                pwrite_q;
    logic [SEL_W-1:0]    sel_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;

    logic [NUM_REQ-1:0]  win_oh;
    logic [IW-1:0]       win_idx;
    logic                any_req;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [SEL_W-1:0]    win_sel;
    logic                win_write;
    logic                acc_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req    (req),
        .ptr    (rr_q),
        .gnt_oh (win_oh),
        .idx    (win_idx),
        .any    (any_req)
    );

    // Payload of the current arbitration winner.
    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_sel   = '0;
        win_write = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IW'(i)) begin
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
                win_sel   = req_sel[i*SEL_W +: SEL_W];
                win_write = req_write[i];
            end
        end
    end

    // The ACCESS cycle in which the counter already holds TIMEOUT-1 is the
    // last one; a pready in that same cycle still completes normally.
    assign acc_timeout = !pready && (cnt_q == CNT_LAST);

    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (any_req) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || acc_timeout) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hresetn) begin
        if (hresetn) begin
            gnt_q    <= '0;
            win_q    <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            sel_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        paddr_q  <= win_addr;
                        pwdata_q <= win_wdata;
                        pwrite_q <= win_write;
                        sel_q    <= win_sel;
                        gnt_q    <= win_oh;
                        win_q    <= win_idx;
                    end
                end
                ST_ACCESS: begin
                    if (pready) begin
                        rdata_q <= pwrite_q ? '0 : prdata;
                        err_q   <= pslverr;
                    end else if (acc_timeout) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_RESP: begin
                    rr_q  <= (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + IW'(1);
                    cnt_q <= '0;
                    gnt_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Bus controls derive from the state register so an asserted reset
    // silences them immediately.
    assign psel      = (state_q == ST_SETUP || state_q == ST_ACCESS) ? sel_q : '0;
    assign penable   = (state_q == ST_ACCESS);
    assign done      = (state_q == ST_RESP) ? gnt_q : '0;
    assign gnt       = gnt_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
